spi_cmd_rx: RTL

SPI_CMD_RX -- requirements
Module: spi_cmd_rx

---
 rtl/vga_pkg.sv | 49 ++++
 rtl/cmd_fifo.sv | 67 ++++++
 rtl/spi_cmd_rx.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// vga_pkg -- definitions shared by the SPI command receiver and its FIFO.
//   op_e        : command opcodes carried in the top nibble of each packet
//   PKT_W       : SPI packet length in bits
//   FIFO_DEPTH  : depth of the command queue toward the framebuffer writer
//   H_ACTIVE/V_ACTIVE : visible raster size used for the optional range check
//   rx_state_e  : receiver FSM states (also exported on the debug port)
//   cmd_t       : one queued command {op, x, y, color}
package vga_pkg;

   typedef enum logic [3:0] {
      OP_NOP   = 4'd0,
      OP_PIXEL = 4'd1,
      OP_CLEAR = 4'd2
   } op_e;

   localparam int PKT_W      = 40;
   localparam int FIFO_DEPTH = 4;
   localparam int H_ACTIVE   = 640;
   localparam int V_ACTIVE   = 480;

   localparam int OP_W    = 4;
   localparam int X_W     = 10;
   localparam int Y_W     = 9;
   localparam int COLOR_W = 12;
   localparam int CMD_W   = OP_W + X_W + Y_W + COLOR_W;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } rx_state_e;

   typedef struct packed {
      logic [OP_W-1:0]    op;
      logic [X_W-1:0]     x;
      logic [Y_W-1:0]     y;
      logic [COLOR_W-1:0] color;
   } cmd_t;

   // Only PIXEL and CLEAR are forwarded downstream.
   function automatic logic op_known(input logic [OP_W-1:0] op);
      return (op == OP_PIXEL) || (op == OP_CLEAR);
   endfunction

   function automatic logic in_active(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
      return (int'(x) < H_ACTIVE) && (int'(y) < V_ACTIVE);
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo -- small synchronous FIFO with registered read/write pointers.
//   clk, reset          : clock, synchronous active-high reset
//   push, push_data     : write request and data (ignored when full unless
//                         a pop happens in the same cycle)
//   pop                 : read request (ignored when empty)
//   head_data           : oldest entry, valid while !empty
//   full, empty         : occupancy flags derived from the pointers
// DEPTH must be a power of two; pointers carry one extra wrap bit so that
// full and empty can be told apart.
module cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 35
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign full      = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign do_pop    = pop && !empty;
   // A pop in the same cycle frees the slot being written, so a full FIFO
   // can still accept.
   assign do_push   = push && (!full || do_pop);
   assign head_data = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q[AW-1:0]] = push_data;
         wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/spi_cmd_rx.sv
// spi_cmd_rx -- SPI (mode 0, MSB first) command receiver for the VGA
// framebuffer writer.
//   clk, reset     : pixel clock, synchronous active-high reset
//   sck, sdi, cs_n : asynchronous SPI inputs from the MCU
//   sdo            : status byte shifted back to the MCU
//   wr_valid/wr_ready, wr_op, wr_x, wr_y, wr_color : command stream out
//   dbg_state      : current receiver FSM state
// Packet (40 bits): {op[39:36], x[35:26], y[25:17], rsvd[16:12], color[11:0]}.
// Status byte: {full, empty, overflow, range_err, frame_err, drop_cnt[2:0]}.
// Handshake: a command transfers on every clk edge where wr_valid && wr_ready;
// while wr_valid is high and wr_ready low, wr_* hold their value.
// Build option SPI_RANGE_CHECK_EN: drop off-screen PIXEL commands and flag
// range_err; without it they are forwarded unchanged and range_err reads 0.
module spi_cmd_rx
   import vga_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               sck,
   input  logic               sdi,
   input  logic               cs_n,
   output logic               sdo,
   output logic               wr_valid,
   input  logic               wr_ready,
   output logic [OP_W-1:0]    wr_op,
   output logic [X_W-1:0]     wr_x,
   output logic [Y_W-1:0]     wr_y,
   output logic [COLOR_W-1:0] wr_color,
   output rx_state_e          dbg_state
);

   // Two-flop synchronizers plus a third flop for edge detection. The cs_n
   // chain resets low: if reset drops mid-packet with cs_n still low no
   // falling edge appears, so the FSM waits for a fresh cs_n high/low.
   logic sck_s1_q, sck_s1_d, sck_s2_q, sck_s2_d, sck_prev_q, sck_prev_d;
   logic cs_s1_q, cs_s1_d, cs_s2_q, cs_s2_d, cs_prev_q, cs_prev_d;
   logic sdi_s1_q, sdi_s1_d, sdi_s2_q, sdi_s2_d;

   logic sck_rise, sck_fall, cs_rise, cs_fall;

   rx_state_e        state_q, state_d;
   logic [5:0]       bit_cnt_q, bit_cnt_d;
   logic [PKT_W-1:0] shreg_q, shreg_d;
   logic             pkt_done_q, pkt_done_d;
   logic [7:0]       sts_sh_q, sts_sh_d;
   logic             overflow_q, overflow_d;
   logic             range_err_q, range_err_d;
   logic             frame_err_q, frame_err_d;
   logic [7:0]       drop_cnt_q, drop_cnt_d;

   cmd_t push_cmd, head_cmd;
   logic fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic range_ok;

   assign sck_rise = sck_s2_q & ~sck_prev_q;
   assign sck_fall = ~sck_s2_q & sck_prev_q;
   assign cs_rise  = cs_s2_q & ~cs_prev_q;
   assign cs_fall  = ~cs_s2_q & cs_prev_q;

   // Reserved bits [16:12] are not forwarded.
   assign push_cmd = {shreg_q[39:17], shreg_q[11:0]};

`ifdef SPI_RANGE_CHECK_EN
   assign range_ok = (push_cmd.op != OP_PIXEL) || in_active(push_cmd.x, push_cmd.y);
`else
   assign range_ok = 1'b1;
`endif

   assign fifo_pop = !fifo_empty && wr_ready;

   always_comb begin
      sck_s1_d   = sck;
      sck_s2_d   = sck_s1_q;
      sck_prev_d = sck_s2_q;
      cs_s1_d    = cs_n;
      cs_s2_d    = cs_s1_q;
      cs_prev_d  = cs_s2_q;
      sdi_s1_d   = sdi;
      sdi_s2_d   = sdi_s1_q;
   end

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shreg_d     = shreg_q;
      pkt_done_d  = 1'b0;
      sts_sh_d    = sts_sh_q;
      overflow_d  = overflow_q;
      range_err_d = range_err_q;
      frame_err_d = frame_err_q;
      drop_cnt_d  = drop_cnt_q;
      fifo_push   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cs_fall) begin
               state_d     = ST_SHIFT;
               bit_cnt_d   = '0;
               // Snapshot status and clear the sticky flags in one step so
               // no event between capture and clear is lost.
               sts_sh_d    = {fifo_full, fifo_empty, overflow_q, range_err_q,
                              frame_err_q, drop_cnt_q[2:0]};
               overflow_d  = 1'b0;
               range_err_d = 1'b0;
               frame_err_d = 1'b0;
            end
         end
         ST_SHIFT: begin
            if (cs_rise) begin
               state_d     = ST_IDLE;
               frame_err_d = 1'b1;
               sts_sh_d    = '0;
            end else if (sck_rise) begin
               shreg_d   = {shreg_q[PKT_W-2:0], sdi_s2_q};
               bit_cnt_d = bit_cnt_q + 6'd1;
               if (bit_cnt_q == 6'(PKT_W - 1)) begin
                  state_d    = ST_DONE;
                  pkt_done_d = 1'b1;
               end
            end
         end
         ST_DONE: begin
            if (cs_rise) begin
               state_d  = ST_IDLE;
               sts_sh_d = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Status advances on each sck fall while selected; zeros follow bit 0.
      if ((state_q != ST_IDLE) && !cs_rise && sck_fall) begin
         sts_sh_d = {sts_sh_q[6:0], 1'b0};
      end

      // Packet disposal one cycle after the last bit; flag sets take
      // precedence over the capture-time clear above.
      if (pkt_done_q && op_known(push_cmd.op)) begin
         if (!range_ok) begin
            range_err_d = 1'b1;
         end else if (fifo_full && !fifo_pop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 8'hFF) begin
               drop_cnt_d = drop_cnt_q + 8'd1;
            end
         end else begin
            fifo_push = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sck_s1_q    <= 1'b0;
         sck_s2_q    <= 1'b0;
         sck_prev_q  <= 1'b0;
         cs_s1_q     <= 1'b0;
         cs_s2_q     <= 1'b0;
         cs_prev_q   <= 1'b0;
         sdi_s1_q    <= 1'b0;
         sdi_s2_q    <= 1'b0;
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         shreg_q     <= '0;
         pkt_done_q  <= 1'b0;
         sts_sh_q    <= '0;
         overflow_q  <= 1'b0;
         range_err_q <= 1'b0;
         frame_err_q <= 1'b0;
         drop_cnt_q  <= '0;
      end else begin
         sck_s1_q    <= sck_s1_d;
         sck_s2_q    <= sck_s2_d;
         sck_prev_q  <= sck_prev_d;
         cs_s1_q     <= cs_s1_d;
         cs_s2_q     <= cs_s2_d;
         cs_prev_q   <= cs_prev_d;
         sdi_s1_q    <= sdi_s1_d;
         sdi_s2_q    <= sdi_s2_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shreg_q     <= shreg_d;
         pkt_done_q  <= pkt_done_d;
         sts_sh_q    <= sts_sh_d;
         overflow_q  <= overflow_d;
         range_err_q <= range_err_d;
         frame_err_q <= frame_err_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (CMD_W)
   ) u_cmd_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (push_cmd),
      .pop       (fifo_pop),
      .head_data (head_cmd),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign wr_valid  = !fifo_empty;
   assign wr_op     = head_cmd.op;
   assign wr_x      = head_cmd.x;
   assign wr_y      = head_cmd.y;
   assign wr_color  = head_cmd.color;
   assign sdo       = sts_sh_q[7];
   assign dbg_state = state_q;

endmodule
